pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised pipeline-stage register, successor to the fixed-field inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a generic data bundle plus a control bundle with a valid/ready handshake, a 2-entry skid buffer, and a synchronous flush.
- Sits between any two CPU pipeline stages.
- Lets hazard logic stall (backpressure) or squash (flush, e.g. on a taken jump/branch) without per-stage custom code.

Parameters:
- DATA_W, 96, width of the datapath bundle (PC+4, operands, immediate, ...).
- CTRL_W, 16, width of the control bundle (WB/M/EX bits, register numbers, jump flag); forced to zero whenever its slot is not valid.
- RST_DATA, 0, reset/flush value of the data registers.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0); one clock
- flush  in  1  synchronous squash of all held entries
- in_valid  in  1  upstream has an entry
- in_ready  out  1  stage can accept; registered
- in_data  in  DATA_W  upstream datapath bundle
- in_ctrl  in  CTRL_W  upstream control bundle
- out_valid  out  1  entry presented downstream
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  held datapath bundle
- out_ctrl  out  CTRL_W  held control bundle; 0 when out_valid=0

Behaviour:
- Storage: main slot (drives outputs) and skid slot (catches the entry accepted while in_ready was still high as out_ready dropped).
- Reset values while rst=0:
  - main/skid valid = 0
  - data = RST_DATA
  - ctrl = 0
  - in_ready = 1
  - out_valid = 0
  - out_ctrl = 0
- Accept condition: in_valid & in_ready. Release condition: out_valid & out_ready.
- in_ready is registered and equals !skid_valid, so it carries no combinational path from out_ready.
- Latency: an entry accepted at edge N appears on out_* after edge N. Throughput is 1 entry/cycle with out_ready held at 1.
- States (main_v, skid_v):
  - EMPTY (0,0): accept → FULL1.
  - FULL1 (1,0):
    - accept & release → FULL1, main takes the new entry.
    - accept & !release → FULL2, skid takes the entry.
    - release & !accept → EMPTY.
  - FULL2 (1,1): in_ready=0.
    - release → FULL1, main ← skid.
    - otherwise hold.
  - State (0,1) is illegal and must never be reached; an assertion fires if it is.
- Order is strictly FIFO; no entry is dropped or duplicated.
- Flush has priority over everything in the same cycle:
  - Next state is EMPTY; both ctrl registers cleared; data registers = RST_DATA.
  - The concurrent input is discarded and a concurrent release still counts as consumed downstream.
  - in_ready is 1 on the cycle after flush.
- Bubble: out_ctrl is 0 whenever out_valid=0, so downstream can use ctrl bits without gating by valid. out_data is don't-care when invalid, but must be deterministic (holds the last value).
- Reset mid-operation: immediate return to EMPTY regardless of state; the handshake restarts cleanly after deassertion.
- in_valid=1 with in_ready=0: the upstream must hold its data. The block ignores the input and does not latch.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- When defined, adds outputs stall_cnt[31:0] and flush_cnt[31:0]. Both reset to 0 and wrap at 2^32.
  - stall_cnt: +1 each cycle with in_valid & !in_ready.
  - flush_cnt: +1 each cycle flush=1 while any slot is valid.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg holds:
  - default widths for each CPU stage bundle (IF_ID_DATA_W, ID_EX_DATA_W, ID_EX_CTRL_W, ...)
  - packed typedefs for those bundles
  - the slot-state encoding constants
- One natural sub-module, pipe_slot: a single valid+data+ctrl register with load/clear, instantiated twice (main, skid).

Test Plan:
- Reset: hold rst=0 for 3 cycles with in_valid=1 → out_valid=0, out_ctrl=0, in_ready=1. After release, sending data 0x11 appears one cycle later.
- Streaming: out_ready=1, send 0x01..0x08 back-to-back → 0x01..0x08 out in order on consecutive cycles, in_ready never drops.
- Backpressure:
  - Send 0xA, 0xB, 0xC back-to-back while out_ready=0 from cycle 2 → 0xA held on output, 0xB in skid, in_ready=0, 0xC held upstream.
  - Raise out_ready → 0xA, 0xB, 0xC delivered in order.
- Flush in FULL2:
  - Assert flush with in_valid=1 (0xD) → next cycle out_valid=0, out_ctrl=0, in_ready=1, 0xD never appears.
  - A subsequent 0xE passes normally.
- Flush and accept same cycle from EMPTY → no entry emerges.
- PIPE_STAGE_PERF_EN build: 5 stall cycles and 2 flushes with valid data → stall_cnt=5, flush_cnt=2. A flush on an empty stage does not increment flush_cnt.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: default bundle
// widths, packed bundle layouts and the (main, skid) slot-state encoding.
package pipe_pkg;

   typedef struct packed {
      logic [31:0] pc_plus4;
      logic [31:0] instr;
   } if_id_data_t;

   typedef struct packed {
      logic [31:0] rs1_val;
      logic [31:0] rs2_val;
      logic [31:0] imm;
   } id_ex_data_t;

   typedef struct packed {
      logic [1:0] wb;
      logic [1:0] m;
      logic [3:0] ex;
      logic [4:0] rd;
      logic       jump;
      logic [1:0] spare;
   } id_ex_ctrl_t;

   typedef struct packed {
      logic [31:0] alu_result;
      logic [31:0] store_data;
      logic [31:0] pc_plus4;
   } ex_mem_data_t;

   typedef struct packed {
      logic [31:0] mem_data;
      logic [31:0] alu_result;
   } mem_wb_data_t;

   localparam int IF_ID_DATA_W  = $bits(if_id_data_t);
   localparam int IF_ID_CTRL_W  = 8;
   localparam int ID_EX_DATA_W  = $bits(id_ex_data_t);
   localparam int ID_EX_CTRL_W  = $bits(id_ex_ctrl_t);
   localparam int EX_MEM_DATA_W = $bits(ex_mem_data_t);
   localparam int EX_MEM_CTRL_W = 8;
   localparam int MEM_WB_DATA_W = $bits(mem_wb_data_t);
   localparam int MEM_WB_CTRL_W = 8;

   // Encoded as {main_valid, skid_valid}.
   typedef enum logic [1:0] {
      SLOT_EMPTY   = 2'b00,
      SLOT_ILLEGAL = 2'b01,
      SLOT_FULL1   = 2'b10,
      SLOT_FULL2   = 2'b11
   } slot_state_e;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline-stage slot: valid flag plus data and control registers.
// clear (flush) beats load, load beats drop; ctrl is zeroed whenever valid falls.
module pipe_slot #(
   parameter int                DATA_W   = 96,
   parameter int                CTRL_W   = 16,
   parameter logic [DATA_W-1:0] RST_DATA = {DATA_W{1'b0}}
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              load,
   input  logic              drop,
   input  logic [DATA_W-1:0] load_data,
   input  logic [CTRL_W-1:0] load_ctrl,
   output logic              valid,
   output logic [DATA_W-1:0] data,
   output logic [CTRL_W-1:0] ctrl
);

   // Slot storage; data is left untouched on drop so the bubble value stays deterministic.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid <= 1'b0;
         data  <= RST_DATA;
         ctrl  <= {CTRL_W{1'b0}};
      end else if (clear) begin
         valid <= 1'b0;
         data  <= RST_DATA;
         ctrl  <= {CTRL_W{1'b0}};
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
         ctrl  <= load_ctrl;
      end else if (drop) begin
         valid <= 1'b0;
         ctrl  <= {CTRL_W{1'b0}};
      end
   end

endmodule

// File: rtl/pipe_stage_reg_chk.sv
// Checker for the pipeline-stage register: the skid slot may never hold an
// entry while the main slot is empty.
module pipe_stage_reg_chk
   import pipe_pkg::*;
(
   input logic        clk,
   input logic        rst,
   input slot_state_e state
);

   // Flag the unreachable (main empty, skid full) combination.
   always @(posedge clk) begin
      if (rst) begin
         assert (state != SLOT_ILLEGAL)
         else $error("pipe_stage_reg: skid slot valid while main slot empty");
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline-stage register with valid/ready handshake, 2-entry skid
// buffer and synchronous flush. Optional counters: define PIPE_STAGE_PERF_EN.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int                DATA_W   = 96,
   parameter int                CTRL_W   = 16,
   parameter logic [DATA_W-1:0] RST_DATA = {DATA_W{1'b0}}
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       flush_cnt
`endif
);

   logic              in_ready_r;
   logic              main_valid_s, skid_valid_s;
   logic [DATA_W-1:0] main_data_s, skid_data_s;
   logic [CTRL_W-1:0] main_ctrl_s, skid_ctrl_s;
   logic              accept_s, release_s;
   logic              main_load_s, main_drop_s, main_from_skid_s;
   logic              skid_load_s, skid_drop_s, skid_next_s;
   logic [DATA_W-1:0] main_load_data_s;
   logic [CTRL_W-1:0] main_load_ctrl_s;
   slot_state_e       state_s;

   assign state_s   = slot_state_e'({main_valid_s, skid_valid_s});
   assign accept_s  = in_valid & in_ready_r;
   assign release_s = main_valid_s & out_ready;

   // Slot load/drop decisions from the current occupancy and handshake.
   always_comb begin
      main_load_s      = 1'b0;
      main_drop_s      = 1'b0;
      main_from_skid_s = 1'b0;
      skid_load_s      = 1'b0;
      skid_drop_s      = 1'b0;
      case (state_s)
         SLOT_EMPTY: begin
            main_load_s = accept_s;
         end
         SLOT_FULL1: begin
            if (accept_s) begin
               main_load_s = release_s;
               skid_load_s = ~release_s;
            end else begin
               main_drop_s = release_s;
            end
         end
         SLOT_FULL2: begin
            if (release_s) begin
               main_load_s      = 1'b1;
               main_from_skid_s = 1'b1;
               skid_drop_s      = 1'b1;
            end else begin
               main_load_s = 1'b0;
            end
         end
         default: begin
            skid_drop_s = 1'b1;
         end
      endcase
   end

   assign main_load_data_s = main_from_skid_s ? skid_data_s : in_data;
   assign main_load_ctrl_s = main_from_skid_s ? skid_ctrl_s : in_ctrl;
   assign skid_next_s      = skid_load_s | (skid_valid_s & ~skid_drop_s);

   pipe_slot #(
      .DATA_W   (DATA_W),
      .CTRL_W   (CTRL_W),
      .RST_DATA (RST_DATA)
   ) u_main (
      .clk       (clk),
      .rst       (rst),
      .clear     (flush),
      .load      (main_load_s),
      .drop      (main_drop_s),
      .load_data (main_load_data_s),
      .load_ctrl (main_load_ctrl_s),
      .valid     (main_valid_s),
      .data      (main_data_s),
      .ctrl      (main_ctrl_s)
   );

   pipe_slot #(
      .DATA_W   (DATA_W),
      .CTRL_W   (CTRL_W),
      .RST_DATA (RST_DATA)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .clear     (flush),
      .load      (skid_load_s),
      .drop      (skid_drop_s),
      .load_data (in_data),
      .load_ctrl (in_ctrl),
      .valid     (skid_valid_s),
      .data      (skid_data_s),
      .ctrl      (skid_ctrl_s)
   );

   // in_ready tracks the next skid occupancy so it never depends on out_ready combinationally.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_ready_r <= 1'b1;
      end else if (flush) begin
         in_ready_r <= 1'b1;
      end else begin
         in_ready_r <= ~skid_next_s;
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = main_valid_s;
   assign out_data  = main_data_s;
   assign out_ctrl  = main_ctrl_s;

`ifdef PIPE_STAGE_PERF_EN
   // Stall and flush event counters, wrapping at 2^32.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= 32'd0;
         flush_cnt <= 32'd0;
      end else begin
         if (in_valid & ~in_ready_r) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
         if (flush & (main_valid_s | skid_valid_s)) begin
            flush_cnt <= flush_cnt + 32'd1;
         end
      end
   end
`endif

   pipe_stage_reg_chk u_chk (
      .clk   (clk),
      .rst   (rst),
      .state (state_s)
   );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: accepted entries are queued from the
// bench's own occupancy model and compared in order as they are released.
module tb_pipe_stage_reg;

   localparam int DATA_W = 96;
   localparam int CTRL_W = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [CTRL_W-1:0] in_ctrl;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CTRL_W-1:0] out_ctrl;
`ifdef PIPE_STAGE_PERF_EN
   logic [31:0]       stall_cnt;
   logic [31:0]       flush_cnt;
`endif

   int n_total = 0;
   int n_bad   = 0;
   logic [DATA_W+CTRL_W-1:0] sb_q[$];
   logic acc_seen = 1'b0;
   int   mdl_stall = 0;
   int   mdl_flush = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_ctrl   (in_ctrl),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ctrl  (out_ctrl)
`ifdef PIPE_STAGE_PERF_EN
      ,
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
`endif
   );

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] mk_data(input int k);
      logic [31:0] w;
      w = k;
      return {w, ~w, w};
   endfunction

   function automatic logic [CTRL_W-1:0] mk_ctrl(input logic [DATA_W-1:0] d);
      return d[15:0] ^ 16'h5A5A;
   endfunction

   // Monitor at the falling edge: inputs are stable for the next rising edge.
   always @(negedge clk) begin
      int sz;
      logic acc;
      logic [DATA_W+CTRL_W-1:0] e;
      if (!rst) begin
         sb_q.delete();
         mdl_stall = 0;
         mdl_flush = 0;
         acc_seen  = 1'b0;
         check_eq("rst_out_valid", out_valid, 0);
         check_eq("rst_out_ctrl", out_ctrl, 0);
         check_eq("rst_in_ready", in_ready, 1);
      end else begin
         sz = sb_q.size();
         check_eq("out_valid", out_valid, (sz > 0));
         check_eq("in_ready", in_ready, (sz < 2));
         if (sz == 0) check_eq("bubble_ctrl", out_ctrl, 0);
`ifdef PIPE_STAGE_PERF_EN
         check_eq("stall_cnt", stall_cnt, mdl_stall);
         check_eq("flush_cnt", flush_cnt, mdl_flush);
`endif
         if (sz > 0 && out_ready) begin
            e = sb_q.pop_front();
            check_eq("out_data", out_data, e[DATA_W+CTRL_W-1:CTRL_W]);
            check_eq("out_ctrl", out_ctrl, e[CTRL_W-1:0]);
         end
         if (in_valid && sz == 2) mdl_stall++;
         if (flush && sz > 0) mdl_flush++;
         acc = in_valid && (sz < 2) && !flush;
         if (flush) sb_q.delete();
         else if (acc) sb_q.push_back({in_data, in_ctrl});
         acc_seen = acc;
      end
   end

   task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic ord, input logic fl);
      in_valid  = v;
      in_data   = d;
      in_ctrl   = mk_ctrl(d);
      out_ready = ord;
      flush     = fl;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [DATA_W-1:0] d, input logic ord);
      for (int k = 0; k < 20; k++) begin
         step(1'b1, d, ord, 1'b0);
         if (acc_seen) return;
      end
      check_eq("send_timeout", acc_seen, 1);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, mk_data(0), 1'b1, 1'b0);
   endtask

   initial begin
      int k;
      logic v;
      rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
      in_valid = 1'b1; in_data = mk_data(32'h99); in_ctrl = mk_ctrl(mk_data(32'h99));
      repeat (3) @(posedge clk);
      #1;
      in_valid = 1'b0;
      rst = 1'b1;
      send(mk_data(32'h11), 1'b1);
      idle(2);

      // streaming
      for (int i = 1; i <= 8; i++) send(mk_data(i), 1'b1);
      idle(2);

      // backpressure: A, B in, C held upstream, then released in order
      send(mk_data(32'hA), 1'b1);
      send(mk_data(32'hB), 1'b0);
      step(1'b1, mk_data(32'hC), 1'b0, 1'b0);
      step(1'b1, mk_data(32'hC), 1'b0, 1'b0);
      send(mk_data(32'hC), 1'b1);
      idle(3);

      // flush in FULL2 with a concurrent input, then a clean entry
      send(mk_data(32'h21), 1'b0);
      send(mk_data(32'h22), 1'b0);
      step(1'b1, mk_data(32'hD), 1'b0, 1'b1);
      step(1'b0, mk_data(0), 1'b1, 1'b0);
      send(mk_data(32'hE), 1'b1);
      idle(2);

      // flush and accept together from empty; flush alongside a release
      step(1'b1, mk_data(32'h31), 1'b1, 1'b1);
      idle(2);
      send(mk_data(32'h41), 1'b1);
      step(1'b1, mk_data(32'h42), 1'b1, 1'b1);
      idle(2);

      // five stall cycles then flush, plus a flush on an empty stage
      send(mk_data(32'h51), 1'b0);
      send(mk_data(32'h52), 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, mk_data(32'h53), 1'b0, 1'b0);
      step(1'b0, mk_data(0), 1'b0, 1'b1);
      step(1'b0, mk_data(0), 1'b0, 1'b1);
      idle(2);

      // random traffic
      k = 32'h100;
      for (int i = 0; i < 300; i++) begin
         v = ($urandom_range(0, 3) != 0);
         step(v, mk_data(k), ($urandom_range(0, 2) != 0), ($urandom_range(0, 40) == 0));
         if (acc_seen) k++;
      end
      idle(3);

      // asynchronous reset in the middle of a full stage
      send(mk_data(32'h61), 1'b0);
      send(mk_data(32'h62), 1'b0);
      in_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      check_eq("async_rst_valid", out_valid, 0);
      check_eq("async_rst_ready", in_ready, 1);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      send(mk_data(32'h71), 1'b1);

      for (int i = 0; i < 10 && sb_q.size() > 0; i++) idle(1);
      idle(1);
      check_eq("drain", sb_q.size(), 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
